// File: rtl/hdmi_pkg.sv
// Shared HDMI timing constants and the scan-out scheduler state encoding.
package hdmi_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_ACTIVE  = 480;
    localparam int V_TOTAL   = 525;
    localparam int N_SAMPLES = 640;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DRAIN
    } sched_state_t;

endpackage

// File: rtl/scope_fb_scheduler_if.sv
// Acquisition write port: valid/ready handshake carrying one sample per transfer.
interface scope_fb_scheduler_if #(
    parameter int AW = 10,
    parameter int DW = 8
);

    logic          acq_valid_i;
    logic          acq_ready_o;
    logic [AW-1:0] acq_addr_i;
    logic [DW-1:0] acq_data_i;
    logic          acq_last_i;

    modport master (
        output acq_valid_i, acq_addr_i, acq_data_i, acq_last_i,
        input  acq_ready_o
    );

    modport slave (
        input  acq_valid_i, acq_addr_i, acq_data_i, acq_last_i,
        output acq_ready_o
    );

endinterface

// File: rtl/scope_fb_scheduler_vblank_detect.sv
// One-cycle pulse on the first clock that counterY sits on the first blanking line.
module vblank_detect #(
    parameter int CNT_W    = 10,
    parameter int V_ACTIVE = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] counter_y,
    output logic             vblank_entry
);

    logic y_at_vblank;
    logic prev_y_is_active;  // previous line was already the blanking-entry line

    assign y_at_vblank = (counter_y == CNT_W'(V_ACTIVE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_y_is_active <= 1'b0;
        end else begin
            prev_y_is_active <= y_at_vblank;
        end
    end

    assign vblank_entry = y_at_vblank && !prev_y_is_active;

endmodule

// File: rtl/scope_fb_scheduler.sv
// Arbitrates the single-port sample RAM between the capture writer and a
// once-per-frame copy into the display line buffer during vertical blanking.
module scope_fb_scheduler #(
    parameter int N_SAMPLES = 640,
    parameter int AW        = 10,
    parameter int DW        = 8,
    parameter int V_ACTIVE  = 480,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  counter_y_i,
    scope_fb_scheduler_if.slave acq,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic [DW-1:0]     ram_wdata_o,
    input  logic [DW-1:0]     ram_rdata_i,
    output logic              lb_we_o,
    output logic [AW-1:0]     lb_addr_o,
    output logic [DW-1:0]     lb_data_o,
    output logic              busy_o,
    output logic              copy_done_o,
    output logic              drop_o,
    output logic              late_o
);

    import hdmi_pkg::*;

    sched_state_t  state;
    logic [AW-1:0] rd_addr;
    logic          pending;
    logic          out_enable;
    logic          lb_we_q;
    logic [AW-1:0] lb_addr_q;
    logic          copy_done_q;
    logic          drop_q;
    logic          late_q;

    logic vblank_entry;
    logic start_copy;
    logic acq_fire;
    logic last_issued;

    vblank_detect #(
        .CNT_W    (CNT_W),
        .V_ACTIVE (V_ACTIVE)
    ) u_vblank_detect (
        .clk          (clk),
        .rst_n        (rst_n),
        .counter_y    (counter_y_i),
        .vblank_entry (vblank_entry)
    );

    assign start_copy  = vblank_entry && pending && (state == IDLE);
    // out_enable keeps ready low while reset is asserted, not just IDLE-decoded.
    assign acq.acq_ready_o = out_enable && (state == IDLE) && !start_copy;
    assign acq_fire    = acq.acq_valid_i && acq.acq_ready_o;
    assign last_issued = (rd_addr == AW'(N_SAMPLES - 1));

    // NOTE: every output gets a default before the branches, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (state == COPY) begin
            ram_en_o   = 1'b1;
            ram_addr_o = rd_addr;
        end else if (acq_fire) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = acq.acq_addr_i;
            ram_wdata_o = acq.acq_data_i;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every branch
    // below sees the values from the start of the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_addr     <= '0;
            pending     <= 1'b0;
            out_enable  <= 1'b0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            copy_done_q <= 1'b0;
            drop_q      <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            out_enable  <= 1'b1;
            // The line-buffer write trails the RAM read by the one-cycle read latency.
            lb_we_q     <= (state == COPY);
            lb_addr_q   <= rd_addr;
            copy_done_q <= (state == COPY) && last_issued;
            drop_q      <= acq_fire && acq.acq_last_i && pending;
            if ((counter_y_i == '0) && (state != IDLE)) begin
                late_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (acq_fire && acq.acq_last_i) begin
                        pending <= 1'b1;
                    end
                    if (start_copy) begin
                        state   <= COPY;
                        rd_addr <= '0;
                    end
                end
                COPY: begin
                    if (last_issued) begin
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    pending <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state != IDLE);
    assign lb_we_o     = lb_we_q;
    assign lb_addr_o   = lb_addr_q;
    assign lb_data_o   = lb_we_q ? ram_rdata_i : '0;
    assign copy_done_o = copy_done_q;
    assign drop_o      = drop_q;
    assign late_o      = late_q;

endmodule

// File: tb/tb_scope_fb_scheduler.sv
// Directed bench for scope_fb_scheduler with a behavioural sample RAM and line buffer.
module tb_scope_fb_scheduler;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int NS    = 640;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] counter_y;
    logic             ram_en, ram_we;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_wdata;
    logic [DW-1:0]    ram_rdata = '0;
    logic             lb_we;
    logic [AW-1:0]    lb_addr;
    logic [DW-1:0]    lb_data;
    logic             busy, copy_done, drop, late;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scope_fb_scheduler_if #(.AW(AW), .DW(DW)) acq_if ();

    scope_fb_scheduler #(
        .N_SAMPLES (NS),
        .AW        (AW),
        .DW        (DW),
        .V_ACTIVE  (480),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .counter_y_i (counter_y),
        .acq         (acq_if.slave),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .lb_we_o     (lb_we),
        .lb_addr_o   (lb_addr),
        .lb_data_o   (lb_data),
        .busy_o      (busy),
        .copy_done_o (copy_done),
        .drop_o      (drop),
        .late_o      (late)
    );

    // Single-port sample RAM, read data one cycle after the read
    logic [DW-1:0] ram_mem [1024];
    always @(posedge clk) begin
        if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= ram_mem[ram_addr];
    end

    // Line buffer capture and event counters, sampled on the falling edge
    logic [DW-1:0] lb_mem [1024];
    int busy_cnt = 0, notready_cnt = 0, lb_wr_cnt = 0, lb_order_err = 0;
    int done_cnt = 0, drop_cnt = 0, ram_wr_busy = 0, ram_rd_cnt = 0;
    int lb_next = 0;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (!acq_if.acq_ready_o) notready_cnt++;
        if (ram_en && ram_we && busy) ram_wr_busy++;
        if (ram_en && !ram_we) ram_rd_cnt++;
        if (drop) drop_cnt++;
        if (lb_we) begin
            lb_mem[lb_addr] = lb_data;
            if (int'(lb_addr) != lb_next) lb_order_err++;
            lb_next++;
            lb_wr_cnt++;
        end
        if (copy_done) begin
            done_cnt++;
            lb_next = 0;
        end
        if (!rst_n) lb_next = 0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [43:0] all_outs();
        return {acq_if.acq_ready_o, ram_en, ram_we, ram_addr, ram_wdata,
                lb_we, lb_addr, lb_data, busy, copy_done, drop, late};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acq_write(input int a, input logic [DW-1:0] d, input logic l);
        bit got = 0;
        acq_if.acq_valid_i = 1'b1;
        acq_if.acq_addr_i  = AW'(a);
        acq_if.acq_data_i  = d;
        acq_if.acq_last_i  = l;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (acq_if.acq_ready_o) got = 1;
            @(posedge clk);
            #1;
        end
        acq_if.acq_valid_i = 1'b0;
        acq_if.acq_last_i  = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL acq_write_timeout: addr %0d never accepted", a);
        end
    endtask

    task automatic write_capture(input logic [DW-1:0] mask);
        for (int k = 0; k < NS; k++) begin
            logic [DW-1:0] kk;
            kk = 8'(k);
            acq_write(k, kk ^ mask, k == NS - 1);
        end
    endtask

    task automatic vblank();
        counter_y = 10'd479;
        tick();
        counter_y = 10'd480;
        tick();
    endtask

    task automatic wait_done(input string name);
        bit got = 0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (copy_done) got = 1;
        end
        tick();
        tick();
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: copy_done never seen", name);
        end
    endtask

    task automatic check_lb(input logic [DW-1:0] mask, input string name);
        int bad = 0;
        int first = -1;
        for (int k = 0; k < NS; k++) begin
            logic [DW-1:0] kk;
            kk = 8'(k);
            if (lb_mem[k] !== (kk ^ mask)) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_lb_data: %0d wrong entries (first at %0d), wanted 0", name, bad, first);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        counter_y = 10'd100;
        acq_if.acq_valid_i = 1'b1;
        acq_if.acq_addr_i  = 10'h3FF;
        acq_if.acq_data_i  = 8'hFF;
        acq_if.acq_last_i  = 1'b1;
        #2;
        checks++;
        if (all_outs() !== 44'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        acq_if.acq_valid_i = 1'b0;
        acq_if.acq_last_i  = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (acq_if.acq_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", acq_if.acq_ready_o);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_copy();
        int b_busy, b_wr, b_ord, b_done, b_drop, b_rd;
        write_capture(8'h00);
        b_busy = busy_cnt; b_wr = lb_wr_cnt; b_ord = lb_order_err;
        b_done = done_cnt; b_drop = drop_cnt; b_rd = ram_rd_cnt;
        vblank();
        wait_done("copy");
        checks++;
        if (busy_cnt - b_busy != NS + 1) begin
            errors++;
            $display("FAIL copy_busy_cycles: got %0d want %0d", busy_cnt - b_busy, NS + 1);
        end
        checks++;
        if (lb_wr_cnt - b_wr != NS) begin
            errors++;
            $display("FAIL copy_lb_writes: got %0d want %0d", lb_wr_cnt - b_wr, NS);
        end
        checks++;
        if (lb_order_err - b_ord != 0) begin
            errors++;
            $display("FAIL copy_lb_order: got %0d address errors want 0", lb_order_err - b_ord);
        end
        checks++;
        if (done_cnt - b_done != 1) begin
            errors++;
            $display("FAIL copy_done_pulses: got %0d want 1", done_cnt - b_done);
        end
        checks++;
        if (drop_cnt - b_drop != 0) begin
            errors++;
            $display("FAIL copy_drop: got %0d want 0", drop_cnt - b_drop);
        end
        checks++;
        if (ram_rd_cnt - b_rd != NS) begin
            errors++;
            $display("FAIL copy_ram_reads: got %0d want %0d", ram_rd_cnt - b_rd, NS);
        end
        check_lb(8'h00, "copy");
        b_busy = busy_cnt;
        vblank();
        repeat (20) tick();
        checks++;
        if (busy_cnt - b_busy != 0) begin
            errors++;
            $display("FAIL copy_pending_cleared: busy for %0d cycles want 0", busy_cnt - b_busy);
        end
    endtask

    task automatic test_no_pending();
        int b_busy = busy_cnt, b_rd = ram_rd_cnt, b_nr = notready_cnt;
        counter_y = 10'd100;
        tick();
        vblank();
        repeat (20) tick();
        checks++;
        if (busy_cnt - b_busy != 0) begin
            errors++;
            $display("FAIL nopend_busy: got %0d busy cycles want 0", busy_cnt - b_busy);
        end
        checks++;
        if (ram_rd_cnt - b_rd != 0) begin
            errors++;
            $display("FAIL nopend_ram_reads: got %0d want 0", ram_rd_cnt - b_rd);
        end
        checks++;
        if (notready_cnt - b_nr != 0) begin
            errors++;
            $display("FAIL nopend_ready: ready low %0d cycles want 0", notready_cnt - b_nr);
        end
        counter_y = 10'd0;
        tick();
        tick();
        checks++;
        if (late !== 1'b0) begin
            errors++;
            $display("FAIL idle_line0_late: got %b want 0", late);
        end
        counter_y = 10'd100;
        tick();
    endtask

    task automatic test_back_to_back();
        int b_nr, b_wb, b_done;
        bit got = 0;
        write_capture(8'hA5);
        counter_y = 10'd479;
        tick();
        counter_y = 10'd480;
        acq_if.acq_valid_i = 1'b1;
        acq_if.acq_addr_i  = 10'd5;
        acq_if.acq_data_i  = 8'h77;
        acq_if.acq_last_i  = 1'b0;
        b_nr = notready_cnt; b_wb = ram_wr_busy; b_done = done_cnt;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = acq_if.acq_ready_o;
        end
        @(posedge clk);
        #1;
        acq_if.acq_valid_i = 1'b0;
        checks++;
        if (!got || notready_cnt - b_nr != NS + 2) begin
            errors++;
            $display("FAIL stall_ready_low: got %0d cycles want %0d", notready_cnt - b_nr, NS + 2);
        end
        checks++;
        if (ram_wr_busy - b_wb != 0) begin
            errors++;
            $display("FAIL stall_ram_write_in_copy: got %0d want 0", ram_wr_busy - b_wb);
        end
        checks++;
        if (done_cnt - b_done != 1) begin
            errors++;
            $display("FAIL stall_done_pulses: got %0d want 1", done_cnt - b_done);
        end
        checks++;
        if (ram_mem[5] !== 8'h77) begin
            errors++;
            $display("FAIL stall_write_landed: got %h want 77", ram_mem[5]);
        end
        check_lb(8'hA5, "stall");
    endtask

    task automatic test_drop();
        int b_drop = drop_cnt, b_done;
        counter_y = 10'd100;
        tick();
        write_capture(8'h11);
        repeat (3) tick();
        checks++;
        if (drop_cnt - b_drop != 0) begin
            errors++;
            $display("FAIL drop_first_capture: got %0d want 0", drop_cnt - b_drop);
        end
        write_capture(8'h3C);
        repeat (3) tick();
        checks++;
        if (drop_cnt - b_drop != 1) begin
            errors++;
            $display("FAIL drop_second_capture: got %0d want 1", drop_cnt - b_drop);
        end
        b_done = done_cnt;
        vblank();
        wait_done("drop");
        checks++;
        if (done_cnt - b_done != 1) begin
            errors++;
            $display("FAIL drop_done_pulses: got %0d want 1", done_cnt - b_done);
        end
        check_lb(8'h3C, "drop");
    endtask

    task automatic test_reset_mid_copy();
        int b_done, b_busy, b_rd;
        counter_y = 10'd100;
        tick();
        write_capture(8'h5A);
        b_done = done_cnt;
        vblank();
        repeat (100) tick();
        checks++;
        if (busy !== 1'b1 || lb_we !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_copy: busy %b lb_we %b want 1 1", busy, lb_we);
        end
        acq_if.acq_valid_i = 1'b1;
        acq_if.acq_addr_i  = 10'd1;
        acq_if.acq_data_i  = 8'h01;
        acq_if.acq_last_i  = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 44'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 0", all_outs());
        end
        #2;
        rst_n = 1'b1;
        acq_if.acq_valid_i = 1'b0;
        acq_if.acq_last_i  = 1'b0;
        tick();
        checks++;
        if (acq_if.acq_ready_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: ready %b busy %b want 1 0", acq_if.acq_ready_o, busy);
        end
        b_busy = busy_cnt; b_rd = ram_rd_cnt;
        vblank();
        repeat (20) tick();
        checks++;
        if (busy_cnt - b_busy != 0 || ram_rd_cnt - b_rd != 0) begin
            errors++;
            $display("FAIL midrst_no_copy: busy %0d reads %0d want 0 0",
                     busy_cnt - b_busy, ram_rd_cnt - b_rd);
        end
        checks++;
        if (done_cnt - b_done != 0) begin
            errors++;
            $display("FAIL midrst_done: got %0d want 0", done_cnt - b_done);
        end
    endtask

    task automatic test_late();
        int b_done;
        counter_y = 10'd100;
        tick();
        write_capture(8'hC3);
        checks++;
        if (late !== 1'b0) begin
            errors++;
            $display("FAIL late_before: got %b want 0", late);
        end
        b_done = done_cnt;
        vblank();
        repeat (10) tick();
        counter_y = 10'd0;
        tick();
        counter_y = 10'd1;
        tick();
        checks++;
        if (late !== 1'b1) begin
            errors++;
            $display("FAIL late_set: got %b want 1", late);
        end
        wait_done("late");
        checks++;
        if (late !== 1'b1 || done_cnt - b_done != 1) begin
            errors++;
            $display("FAIL late_sticky: late %b done %0d want 1 1", late, done_cnt - b_done);
        end
        vblank();
        repeat (5) tick();
        checks++;
        if (late !== 1'b1) begin
            errors++;
            $display("FAIL late_hold: got %b want 1", late);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (late !== 1'b0) begin
            errors++;
            $display("FAIL late_reset: got %b want 0", late);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        acq_if.acq_valid_i = 1'b0;
        acq_if.acq_addr_i  = '0;
        acq_if.acq_data_i  = '0;
        acq_if.acq_last_i  = 1'b0;
        test_reset();
        test_copy();
        test_no_pending();
        test_back_to_back();
        test_drop();
        test_reset_mid_copy();
        test_late();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
